// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and datapath width defaults.
// Imported by the execute stage and by the control unit.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_IMM_W  = 16;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Execute-stage bus: operands and control in from decode, results out to
// data memory, writeback and PC branch logic.
interface alu_exec_stage_if
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int IMM_W  = ALU_IMM_W
);
    logic [2:0]        alu_control;
    logic              alu_src;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] rd2;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] sign_imm;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic [DATA_W-1:0] alu_result_q;
    logic              zero_q;

    modport master (
        output alu_control, alu_src, src_a, rd2, imm,
        input  sign_imm, src_b, alu_result, zero, alu_result_q, zero_q
    );

    modport slave (
        input  alu_control, alu_src, src_a, rd2, imm,
        output sign_imm, src_b, alu_result, zero, alu_result_q, zero_q
    );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: one of seven operations on a/b plus the zero flag
// used by beq. Add/sub wrap silently.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic [2:0]        alu_control_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    logic slt_bit;

    assign slt_bit = ($signed(a_i) < $signed(b_i)) ? 1'b1 : 1'b0;

    always_comb begin
        result_o = '0;
        case (alu_control_i)
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLT:  result_o = {{(DATA_W-1){1'b0}}, slt_bit};
            ALU_ANDN: result_o = a_i & ~b_i;
            ALU_ORN:  result_o = a_i | ~b_i;
            // 3'b011 is reserved and yields zero, so zero_o reads 1
            default:  result_o = '0;
        endcase
    end

    assign zero_o = ~|result_o;

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage of the single-cycle MIPS core: immediate sign extension,
// operand B select, ALU, and a one-cycle registered copy of result/zero.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int IMM_W  = ALU_IMM_W
) (
    input  logic              clk,
    input  logic              reset,
    alu_exec_stage_if.slave   bus
);

    logic [DATA_W-1:0] sign_imm;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic [DATA_W-1:0] alu_result_d;
    logic              zero_d;
    logic [DATA_W-1:0] alu_result_q;
    logic              zero_q;

    assign sign_imm = {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
    assign src_b    = bus.alu_src ? sign_imm : bus.rd2;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .alu_control_i (bus.alu_control),
        .a_i           (bus.src_a),
        .b_i           (src_b),
        .result_o      (alu_result),
        .zero_o        (zero)
    );

    assign alu_result_d = alu_result;
    assign zero_d       = zero;

    // Reset wins over the incoming data; the combinational path ignores it.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result_q <= '0;
            zero_q       <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            zero_q       <= zero_d;
        end
    end

    assign bus.sign_imm     = sign_imm;
    assign bus.src_b        = src_b;
    assign bus.alu_result   = alu_result;
    assign bus.zero         = zero;
    assign bus.alu_result_q = alu_result_q;
    assign bus.zero_q       = zero_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage; expected values are hand-computed.
module tb_alu_exec_stage;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    alu_exec_stage_if #(.DATA_W(32), .IMM_W(16)) bus ();

    alu_exec_stage #(
        .DATA_W (32),
        .IMM_W  (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a vector at the falling edge and let the combinational outputs settle.
    task automatic apply(input logic [2:0] ctrl, input logic src,
                         input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
        @(negedge clk);
        bus.alu_control = ctrl;
        bus.alu_src     = src;
        bus.src_a       = a;
        bus.rd2         = b;
        bus.imm         = im;
        #1;
        $display("[TB] ctrl=%03b src=%0b a=0x%08h rd2=0x%08h imm=0x%04h -> result=0x%08h zero=%0b",
                 ctrl, src, a, b, im, bus.alu_result, bus.zero);
    endtask

    task automatic edge_then_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;

        // Reset with reserved op on the inputs: comb zero=1, registered zero_q must be 0.
        apply(3'b011, 1'b0, 32'h1234_5678, 32'h9abc_def0, 16'h0000);
        chk("rsvd_result", bus.alu_result, 32'h0);
        chk("rsvd_zero", {31'b0, bus.zero}, 32'h1);
        edge_then_sample();
        chk("rst_result_q", bus.alu_result_q, 32'h0);
        chk("rst_zero_q", {31'b0, bus.zero_q}, 32'h0);

        @(negedge clk);
        reset = 1'b0;

        // 1. ADD 5+7
        apply(3'b010, 1'b0, 32'd5, 32'd7, 16'h0000);
        chk("add_src_b", bus.src_b, 32'd7);
        chk("add_result", bus.alu_result, 32'd12);
        chk("add_zero", {31'b0, bus.zero}, 32'h0);
        edge_then_sample();
        chk("add_result_q", bus.alu_result_q, 32'd12);
        chk("add_zero_q", {31'b0, bus.zero_q}, 32'h0);

        // 2. SUB equal operands -> beq taken
        apply(3'b110, 1'b0, 32'h0000_0007, 32'h0000_0007, 16'h0000);
        chk("sub_eq_result", bus.alu_result, 32'h0);
        chk("sub_eq_zero", {31'b0, bus.zero}, 32'h1);
        edge_then_sample();
        chk("sub_eq_zero_q", {31'b0, bus.zero_q}, 32'h1);

        // SUB wrap 0-1
        apply(3'b110, 1'b0, 32'h0, 32'h1, 16'h0000);
        chk("sub_wrap", bus.alu_result, 32'hFFFF_FFFF);

        // 3. SLT signed
        apply(3'b111, 1'b0, 32'hFFFF_FFFF, 32'd1, 16'h0000);
        chk("slt_neg_lt_pos", bus.alu_result, 32'd1);
        apply(3'b111, 1'b0, 32'd1, 32'hFFFF_FFFF, 16'h0000);
        chk("slt_pos_lt_neg", bus.alu_result, 32'd0);
        apply(3'b111, 1'b0, 32'd3, 32'd5, 16'h0000);
        chk("slt_3_lt_5", bus.alu_result, 32'd1);

        // 4. Sign extension via the immediate operand
        apply(3'b010, 1'b1, 32'h10, 32'hDEAD_BEEF, 16'h8000);
        chk("imm_neg_sign_imm", bus.sign_imm, 32'hFFFF_8000);
        chk("imm_neg_src_b", bus.src_b, 32'hFFFF_8000);
        chk("imm_neg_result", bus.alu_result, 32'hFFFF_8010);
        apply(3'b010, 1'b1, 32'h10, 32'hDEAD_BEEF, 16'h7FFF);
        chk("imm_pos_sign_imm", bus.sign_imm, 32'h0000_7FFF);
        chk("imm_pos_result", bus.alu_result, 32'h0000_800F);

        // 5. ADD overflow wraps; logic ops
        apply(3'b010, 1'b0, 32'h7FFF_FFFF, 32'd1, 16'h0000);
        chk("add_wrap_result", bus.alu_result, 32'h8000_0000);
        chk("add_wrap_zero", {31'b0, bus.zero}, 32'h0);
        apply(3'b000, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 16'h0000);
        chk("and_result", bus.alu_result, 32'h0000_00F0);
        apply(3'b001, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 16'h0000);
        chk("or_result", bus.alu_result, 32'h0000_FFF0);
        apply(3'b100, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 16'h0000);
        chk("andn_result", bus.alu_result, 32'h0000_F000);
        apply(3'b101, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 16'h0000);
        chk("orn_result", bus.alu_result, 32'hFFFF_F0FF);

        // 6. Mid-run reset dominates, combinational path unaffected
        apply(3'b010, 1'b0, 32'd5, 32'd7, 16'h0000);
        edge_then_sample();
        chk("pre_rst_result_q", bus.alu_result_q, 32'd12);
        @(negedge clk);
        reset = 1'b1;
        edge_then_sample();
        chk("mid_rst_result_q", bus.alu_result_q, 32'h0);
        chk("mid_rst_zero_q", {31'b0, bus.zero_q}, 32'h0);
        chk("mid_rst_comb_result", bus.alu_result, 32'd12);
        @(negedge clk);
        reset = 1'b0;
        edge_then_sample();
        chk("post_rst_result_q", bus.alu_result_q, 32'd12);
        chk("post_rst_zero_q", {31'b0, bus.zero_q}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
